operand_bypass_stage: RTL

- Register-read/operand-select pipeline stage between decode and execute.
- Keeps a small FIFO of written-back results that are not yet committed to the GPR file.
- For each source-operand request, picks the newest matching value among register file, FIFO, same-cycle writeback and immediate.
- Registers both the selected 32-bit operand and the 3-bit select code (the code drives a downstream 8-input 32-bit operand mux), behind a valid/ready handshake.

---
 rtl/operand_bypass_stage.sv | 112 +++++++++++
 1 files changed

// File: rtl/operand_bypass_stage.sv
// operand_bypass_stage: picks the newest operand value (rf/history/writeback/imm) and registers it behind valid/ready
module operand_bypass_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [WIDTH-1:0] in_rf_data,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_use_imm,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             rf_retire,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_sel,
  output logic [2:0]       hist_count,
  output logic             ovf_err,
  output logic             unf_err
);
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [TAG_W-1:0] tag_d [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [WIDTH-1:0] mux_in [8];
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, slot, hit_slot;
  logic [2:0] cnt_q, cnt_d, out_sel_q, out_sel_d, sel;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, ovf_q, ovf_d, unf_q, unf_d;
  logic full, empty, push, pop, accept, hit;

  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sel    = out_sel_q;
  assign hist_count = cnt_q;
  assign ovf_err    = ovf_q;
  assign unf_err    = unf_q;

  always_comb begin
    full     = cnt_q == 3'(DEPTH);
    empty    = cnt_q == 3'd0;
    push     = wb_valid && (!full || rf_retire);
    pop      = rf_retire && !empty;
    vld_d    = vld_q;
    tag_d    = tag_q;
    data_d   = data_q;
    if (pop) vld_d[rd_ptr_q] = 1'b0;
    if (push) begin
      vld_d[wr_ptr_q]  = 1'b1;
      tag_d[wr_ptr_q]  = wb_tag;
      data_d[wr_ptr_q] = wb_data;
    end
    wr_ptr_d = wr_ptr_q + 2'(push);
    rd_ptr_d = rd_ptr_q + 2'(pop);
    cnt_d    = cnt_q + 3'(push) - 3'(pop);
    ovf_d    = ovf_q | (wb_valid & full & !rf_retire);
    unf_d    = unf_q | (rf_retire & empty);
    hit      = 1'b0;
    hit_slot = 2'd0;
    slot     = 2'd0;
    // oldest first so the newest match overwrites; pre-pop state keeps retiring entries visible
    for (int k = DEPTH - 1; k >= 0; k--) begin
      slot = wr_ptr_q - 2'(k) - 2'd1;
      if (vld_q[slot] && tag_q[slot] == in_tag) begin
        hit      = 1'b1;
        hit_slot = slot;
      end
    end
    sel = in_use_imm ? 3'd7 : (wb_valid && wb_tag == in_tag) ? 3'd5 : hit ? 3'd1 + 3'(hit_slot) : 3'd0;
    mux_in = '{in_rf_data, data_q[0], data_q[1], data_q[2], data_q[3], wb_data, {WIDTH{1'b0}}, in_imm};
    out_valid_d = accept ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
    out_sel_d   = accept ? sel : out_sel_q;
    out_data_d  = accept ? mux_in[sel] : out_data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q       <= '0;
      tag_q       <= '{default: '0};
      data_q      <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end
endmodule
